// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receive path and its benches.
package uart_pkg;

    localparam int UART_BYTE_W   = 8;
    localparam int CLKS_PER_BIT  = 217;   // 25 MHz / 115200 baud
    localparam int BIT_PERIOD_NS = 8680;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never reset; validity is tracked by the pointers in the parent.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind the UART receiver, with occupancy
// status and a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int WIDTH        = UART_BYTE_W,
    parameter int AFULL_THRESH = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_dv_i,
    input  logic [WIDTH-1:0]         rx_byte_i,
    output logic                     rd_valid_o,
    output logic [WIDTH-1:0]         rd_data_o,
    input  logic                     rd_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic                     overflow_o,
    input  logic                     overflow_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          drop;

    // Read handshake: the head byte transfers on any rising edge where
    // rd_valid_o and rd_ready_i are both high; rd_data_o holds the head
    // until then. rd_ready_i only feeds next-state logic, never an output.
    assign pop  = rd_valid_o && rd_ready_i;
    assign push = rx_dv_i && (!full_o || pop);
    assign drop = rx_dv_i && full_o && !pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // A fresh drop outranks a clear in the same cycle so no loss goes unreported.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (overflow_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr),
        .wdata_i (rx_byte_i),
        .raddr_i (rd_ptr),
        .rdata_o (rd_data_o)
    );

    assign count_o       = count;
    assign empty_o       = (count == '0);
    assign full_o        = (count == CW'(DEPTH));
    assign almost_full_o = (count >= CW'(AFULL_THRESH));
    assign rd_valid_o    = !empty_o;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue scoreboard for popped bytes plus a
// small occupancy/overflow model for the status outputs.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic             clk_i;
    logic             rst_i;
    logic             rx_dv_i;
    uart_byte_t       rx_byte_i;
    logic             rd_valid_o;
    uart_byte_t       rd_data_o;
    logic             rd_ready_i;
    logic [4:0]       count_o;
    logic             empty_o;
    logic             full_o;
    logic             almost_full_o;
    logic             overflow_o;
    logic             overflow_clr_i;

    uart_rx_fifo #(
        .DEPTH        (DEPTH),
        .WIDTH        (8),
        .AFULL_THRESH (AFT)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_dv_i        (rx_dv_i),
        .rx_byte_i      (rx_byte_i),
        .rd_valid_o     (rd_valid_o),
        .rd_data_o      (rd_data_o),
        .rd_ready_i     (rd_ready_i),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_full_o  (almost_full_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // scoreboard and model state
    logic [7:0] exp_q[$];
    int         m_cnt;
    logic       m_ovf;
    logic [7:0] last_pop;
    int         n_chk;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(count_o), 32'(m_cnt));
        check({tag, "_empty"}, 32'(empty_o), 32'(m_cnt == 0));
        check({tag, "_valid"}, 32'(rd_valid_o), 32'(m_cnt != 0));
        check({tag, "_full"}, 32'(full_o), 32'(m_cnt == DEPTH));
        check({tag, "_afull"}, 32'(almost_full_o), 32'(m_cnt >= AFT));
        check({tag, "_ovf"}, 32'(overflow_o), 32'(m_ovf));
    endtask

    // One clock of stimulus, applied at the falling edge and returning at the next one.
    task automatic step(input logic dv, input logic [7:0] b, input logic rdy, input logic clr);
        logic do_pop;
        logic do_push;
        logic do_drop;
        rx_dv_i        = dv;
        rx_byte_i      = b;
        rd_ready_i     = rdy;
        overflow_clr_i = clr;
        #1;
        do_pop  = rdy && (m_cnt > 0);
        do_push = dv && ((m_cnt < DEPTH) || do_pop);
        do_drop = dv && !do_push;
        if (do_pop) begin
            last_pop = rd_data_o;
            if (exp_q.size() == 0) begin
                check("pop_underflow", 32'(rd_data_o), 32'hFFFF_FFFF);
            end else begin
                check("pop_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
            end
        end
        if (do_push) exp_q.push_back(b);
        @(posedge clk_i);
        m_cnt = m_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        if (do_drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        rx_dv_i        = 1'b0;
        rd_ready_i     = 1'b0;
        overflow_clr_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < DEPTH; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; m_cnt = 0; m_ovf = 1'b0; last_pop = 8'h00;
        rst_i = 1'b1; rx_dv_i = 1'b0; rx_byte_i = 8'h00;
        rd_ready_i = 1'b0; overflow_clr_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_status("in_reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_status("after_reset");

        // 1: two bytes held, then read out in order
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        step(1'b1, 8'hCD, 1'b0, 1'b0);
        check_status("t1_two");
        check("t1_head", 32'(rd_data_o), 32'h0000_00AB);
        drain(2);
        check_status("t1_drained");
        check("t1_last", 32'(last_pop), 32'h0000_00CD);

        // ready with nothing stored moves nothing
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_status("idle_ready");

        // 2: fill, almost-full threshold, overflow drop
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            check_status("t2_fill");
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check_status("t2_drop");
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check_status("t2_drain");
        end
        check("t2_last", 32'(last_pop), 32'h0000_000F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_status("t2_clr");

        // 3: push and pop together while full
        fill(8'h20);
        check_status("t3_full");
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check_status("t3_both");
        drain(DEPTH);
        check("t3_last", 32'(last_pop), 32'h0000_0055);
        check_status("t3_empty");

        // 4: streaming through the pointer wrap; empty push+ready holds the byte
        step(1'b1, 8'h10, 1'b1, 1'b0);
        check_status("t4_first");
        for (int i = 1; i < 40; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
            check("t4_cnt_le1", 32'(count_o <= 5'd1), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_last", 32'(last_pop), 32'h0000_0037);
        check_status("t4_empty");

        // 5: drop beats a simultaneous clear
        fill(8'h40);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check_status("t5_set");
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        check("t5_set_wins", 32'(overflow_o), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_cleared", 32'(overflow_o), 32'd0);
        drain(DEPTH);
        check_status("t5_empty");

        // 6: asynchronous reset mid-cycle with five bytes stored and overflow set
        fill(8'h60);
        step(1'b1, 8'hFE, 1'b0, 1'b0);
        drain(11);
        check_status("t6_five");
        #2;
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        check_status("t6_async");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        check("t6_head", 32'(rd_data_o), 32'h0000_003C);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_readback", 32'(last_pop), 32'h0000_003C);
        check_status("t6_end");
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures every single-cycle byte-valid strobe and its byte into a first-word-fall-through FIFO. It presents the bytes to the consumer (command parser or loopback logic) over a valid/ready handshake. It also reports occupancy and a sticky overflow flag, so bytes arriving at 115200 baud are never silently lost.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two, at least 2
WIDTH, 8, data width in bits (UART byte)
AFULL_THRESH, 12, almost_full_o asserts when count_o >= this value; must satisfy 1 <= AFULL_THRESH <= DEPTH

Ports:
clk_i  input  1  system clock (25 MHz)
rst_i  input  1  asynchronous, active-high reset
rx_dv_i  input  1  single-cycle byte-valid strobe from the UART receiver
rx_byte_i  input  WIDTH  received byte; sampled only when rx_dv_i=1
rd_valid_o  output  1  head entry available
rd_data_o  output  WIDTH  head entry (first-word-fall-through)
rd_ready_i  input  1  consumer accepts the head entry
count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
empty_o  output  1  count_o==0
full_o  output  1  count_o==DEPTH
almost_full_o  output  1  count_o>=AFULL_THRESH
overflow_o  output  1  sticky: a byte was dropped
overflow_clr_i  input  1  clears overflow_o

Behaviour:
- Interface decision: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset (asserted at any time, including mid-transfer): wr_ptr=0, rd_ptr=0, count=0, overflow_o=0. Stored contents are discarded and need no reset.
- Output values during and after reset: rd_valid_o=0, empty_o=1, full_o=0, almost_full_o=0, count_o=0.
- rd_data_o is don't-care while rd_valid_o=0.
- Push: rx_dv_i=1 and (not full, or pop in the same cycle) -> mem[wr_ptr]<=rx_byte_i, wr_ptr increments.
- Pop: rd_valid_o=1 and rd_ready_i=1 -> rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count_o: +1 on push only, -1 on pop only, unchanged on both or neither. All status outputs derive from count_o registered state.
- FWFT: rd_valid_o = !empty_o, and rd_data_o = mem[rd_ptr], combinational from storage.
- Write-to-read latency is 1 cycle: a byte pushed at edge N is visible on rd_data_o with rd_valid_o=1 after edge N.
- Empty FIFO with push and rd_ready_i=1 in the same cycle: no pop, because rd_valid_o=0. The byte is held.
- Full FIFO with push and pop in the same cycle: both occur, the byte is accepted, and count stays at DEPTH. overflow_o is not set.
- Full FIFO with push and no pop: the byte is dropped, storage and pointers are unchanged, and overflow_o<=1.
- overflow_o stays set until overflow_clr_i=1. If a clear and a new drop occur in the same cycle, set wins.
- rd_ready_i with rd_valid_o=0: ignored, no pointer movement.
- Back-to-back rx_dv_i on consecutive cycles is supported. The real receiver cannot produce this, but the bench exercises it.
- No combinational path from rd_ready_i to any output other than the next-state logic.

Decomposition:
- Shared package uart_pkg holds:
  - UART_BYTE_W=8
  - CLKS_PER_BIT=217 (25 MHz / 115200)
  - BIT_PERIOD_NS=8680 for benches
  - typedef uart_byte_t logic [UART_BYTE_W-1:0]
- One sub-module, uart_fifo_mem: the DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port.
- Pointer, count and flag logic stays in uart_rx_fifo.

Test Plan:
1. Reset, then push 8'hAB, then 8'hCD with rd_ready_i=0 -> count_o=2 and rd_data_o=8'hAB. Raise rd_ready_i for 2 cycles -> 8'hAB then 8'hCD, ending with empty_o=1 and count_o=0.
2. Push 16 bytes 8'h00..8'h0F -> full_o=1, and almost_full_o=1 from count_o=12. A 17th push of 8'hFF -> overflow_o=1, count_o=16. Draining yields 8'h00..8'h0F only, with no 8'hFF.
3. FIFO full, push 8'h55 while popping -> count_o stays 16, overflow_o stays 0, and the last drained byte is 8'h55.
4. Pointer wrap: push and pop 40 bytes continuously (8'h10+i) -> every popped byte matches in order and count_o never exceeds 1.
5. Set overflow, then assert overflow_clr_i in the same cycle as another full-FIFO drop -> overflow_o stays 1. Next cycle with overflow_clr_i and no drop -> overflow_o=0.
6. Assert rst_i asynchronously mid-cycle with count_o=5 -> immediately empty_o=1, rd_valid_o=0, count_o=0, overflow_o=0. After release, a push of 8'h3C is read back as 8'h3C.
